// File: rtl/seq_mult_param_if.sv
// Handshake bundle for the sequential multiplier: operand side, result side and status.
interface seq_mult_param_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               full;
    logic               sgn;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] y;
    logic               busy;

    // Producer/consumer side of the multiplier
    modport master (
        output in_valid, a, b, full, sgn, out_ready,
        input  in_ready, out_valid, y, busy
    );

    // The multiplier itself
    modport slave (
        input  in_valid, a, b, full, sgn, out_ready,
        output in_ready, out_valid, y, busy
    );
endinterface

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier retiring DIGIT multiplier bits per cycle.
// Produces a truncated (low WIDTH) or full (2*WIDTH) product, unsigned or
// two's-complement, behind valid/ready handshakes on both sides.
module seq_mult_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    seq_mult_param_if.slave bus
);
    localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("seq_mult_param: WIDTH must be at least 2");
        end
        if ((DIGIT < 1) ? 1'b1 : ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
            $error("seq_mult_param: DIGIT must divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_next;
    logic [PW-1:0]   mcand;
    logic [PW-1:0]   pp;
    logic [WIDTH-1:0] mplier;
    logic            full_q;
    logic            sgn_q;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   y_q;
    logic            take_in;
    logic            last_step;

    assign last_step = (cnt == CW'(N - 1));

    // State register; reset drops any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs; DONE can hand over straight to BUSY
    always_comb begin
        state_next    = state;
        take_in       = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    take_in    = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                bus.busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        take_in    = 1'b1;
                        state_next = BUSY;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (rst) begin
            bus.in_ready = 1'b1;
        end
    end

    // Add this cycle's DIGIT partial products; b's MSB carries negative weight when signed
    always_comb begin
        acc_next = acc;
        pp       = '0;
        for (int j = 0; j < DIGIT; j++) begin
            if (mplier[j]) begin
                pp = mcand << j;
                if (sgn_q && last_step && (j == DIGIT - 1)) begin
                    acc_next = acc_next - pp;
                end else begin
                    acc_next = acc_next + pp;
                end
            end
        end
    end

    // Operand capture, shift-add iteration and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            full_q <= 1'b0;
            sgn_q  <= 1'b0;
            cnt    <= '0;
            y_q    <= '0;
        end else if (take_in) begin
            acc    <= '0;
            cnt    <= '0;
            mcand  <= bus.sgn ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a}
                              : {{WIDTH{1'b0}}, bus.a};
            mplier <= bus.b;
            full_q <= bus.full;
            sgn_q  <= bus.sgn;
        end else if (state == BUSY) begin
            acc    <= acc_next;
            mcand  <= mcand << DIGIT;
            mplier <= mplier >> DIGIT;
            cnt    <= cnt + 1'b1;
            if (last_step) begin
                y_q <= full_q ? acc_next : {{WIDTH{1'b0}}, acc_next[WIDTH-1:0]};
            end
        end
    end

    assign bus.y = y_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param: directed cases plus random operands
// against an arithmetic reference, on a WIDTH=8/DIGIT=1 and a WIDTH=16/DIGIT=4 instance.
module tb_seq_mult_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seq_mult_param_if #(.WIDTH(8))  bus8 ();
    seq_mult_param_if #(.WIDTH(16)) bus16 ();

    seq_mult_param #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    seq_mult_param #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Product from plain integer arithmetic on the operand values
    function automatic logic [31:0] ref_model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                              input logic fl, input logic sg);
        longint        x;
        longint        z;
        logic [63:0]   p;
        logic [63:0]   m;
        x = longint'(av) & ((64'd1 << w) - 64'd1);
        z = longint'(bv) & ((64'd1 << w) - 64'd1);
        if (sg && av[w-1]) x = x - (longint'(1) << w);
        if (sg && bv[w-1]) z = z - (longint'(1) << w);
        p = 64'(x * z);
        m = fl ? ((64'd1 << (2 * w)) - 64'd1) : ((64'd1 << w) - 64'd1);
        return 32'(p & m);
    endfunction

    task automatic drive_in(input int sel, input logic v, input logic [15:0] av, input logic [15:0] bv,
                            input logic fl, input logic sg);
        if (sel == 0) begin
            bus8.in_valid = v;
            bus8.a        = av[7:0];
            bus8.b        = bv[7:0];
            bus8.full     = fl;
            bus8.sgn      = sg;
        end else begin
            bus16.in_valid = v;
            bus16.a        = av;
            bus16.b        = bv;
            bus16.full     = fl;
            bus16.sgn      = sg;
        end
    endtask

    task automatic drive_or(input int sel, input logic r);
        if (sel == 0) bus8.out_ready = r;
        else          bus16.out_ready = r;
    endtask

    function automatic logic [31:0] get_y(input int sel);
        return (sel == 0) ? {16'h0, bus8.y} : bus16.y;
    endfunction

    function automatic logic get_ov(input int sel);
        return (sel == 0) ? bus8.out_valid : bus16.out_valid;
    endfunction

    // Wait for out_valid after a transfer edge; returns edges elapsed
    task automatic wait_result(input int sel, output int lat);
        lat = 0;
        while (!get_ov(sel) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // One full operation: transfer, latency, result, then pop the result
    task automatic applyStimulus(input int sel, input string tag, input logic [15:0] av, input logic [15:0] bv,
                                 input logic fl, input logic sg, input logic [31:0] exp);
        int lat;
        @(negedge clk);
        drive_in(sel, 1'b1, av, bv, fl, sg);
        @(negedge clk);
        drive_in(sel, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        wait_result(sel, lat);
        checkOutput({tag, "_lat"}, 32'(lat), (sel == 0) ? 32'd8 : 32'd4);
        checkOutput(tag, get_y(sel), exp);
        drive_or(sel, 1'b1);
        @(negedge clk);
        drive_or(sel, 1'b0);
        checkOutput({tag, "_pop"}, 32'(get_ov(sel)), 32'd0);
    endtask

    initial begin
        int            lat;
        logic [15:0]   ra;
        logic [15:0]   rb;
        logic          rf;
        logic          rs;
        int            sel;
        int            w;

        drive_in(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        drive_in(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        drive_or(0, 1'b0);
        drive_or(1, 1'b0);

        // Reset behaviour
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 32'(bus8.in_ready), 32'd1);
        rst = 1'b0;
        checkOutput("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        checkOutput("rst_y", get_y(0), 32'd0);
        checkOutput("rst_busy", 32'(bus8.busy), 32'd0);
        checkOutput("rst_y16", get_y(1), 32'd0);

        // Directed WIDTH=8 cases
        applyStimulus(0, "u_trunc", 16'h5A, 16'h3C, 1'b0, 1'b0, 32'h0018);
        applyStimulus(0, "u_full", 16'h5A, 16'h3C, 1'b1, 1'b0, 32'h1518);
        applyStimulus(0, "s_ff_02", 16'hFF, 16'h02, 1'b1, 1'b1, 32'hFFFE);
        applyStimulus(0, "u_ff_02", 16'hFF, 16'h02, 1'b1, 1'b0, 32'h01FE);
        applyStimulus(0, "u_ff_ff", 16'hFF, 16'hFF, 1'b1, 1'b0, 32'hFE01);
        applyStimulus(0, "s_80_80", 16'h80, 16'h80, 1'b1, 1'b1, 32'h4000);
        applyStimulus(0, "s_80_7f", 16'h80, 16'h7F, 1'b1, 1'b1, 32'hC080);
        applyStimulus(0, "zero_a", 16'h00, 16'hB7, 1'b1, 1'b1, 32'h0000);
        applyStimulus(0, "s_trunc", 16'h80, 16'h7F, 1'b0, 1'b1, 32'h0080);

        // Backpressure and DONE-to-BUSY handover
        @(negedge clk);
        drive_in(0, 1'b1, 16'h12, 16'h34, 1'b1, 1'b0);
        @(negedge clk);
        drive_in(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        wait_result(0, lat);
        checkOutput("bp_lat", 32'(lat), 32'd8);
        drive_in(0, 1'b1, 16'h07, 16'h09, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_y", get_y(0), 32'h03A8);
            checkOutput("bp_in_ready", 32'(bus8.in_ready), 32'd0);
            checkOutput("bp_busy", 32'(bus8.busy), 32'd1);
            checkOutput("bp_out_valid", 32'(bus8.out_valid), 32'd1);
        end
        drive_or(0, 1'b1);
        #1;
        checkOutput("bp_comb_ready", 32'(bus8.in_ready), 32'd1);
        @(negedge clk);
        drive_or(0, 1'b0);
        drive_in(0, 1'b0, 16'hEE, 16'hEE, 1'b0, 1'b1);
        checkOutput("handover_busy", 32'(bus8.busy), 32'd1);
        checkOutput("handover_ov", 32'(bus8.out_valid), 32'd0);
        wait_result(0, lat);
        checkOutput("handover_lat", 32'(lat), 32'd8);
        checkOutput("handover_y", get_y(0), 32'h003F);
        drive_or(0, 1'b1);
        @(negedge clk);
        drive_or(0, 1'b0);

        // Reset in the 4th BUSY cycle
        @(negedge clk);
        drive_in(0, 1'b1, 16'hAB, 16'hCD, 1'b1, 1'b0);
        @(negedge clk);
        drive_in(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_ov", 32'(bus8.out_valid), 32'd0);
        checkOutput("mid_rst_y", get_y(0), 32'd0);
        checkOutput("mid_rst_busy", 32'(bus8.busy), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(bus8.in_ready), 32'd1);
        repeat (10) @(negedge clk);
        checkOutput("mid_rst_no_result", 32'(bus8.out_valid), 32'd0);
        applyStimulus(0, "after_rst", 16'h03, 16'h05, 1'b1, 1'b0, 32'h000F);

        // WIDTH=16, DIGIT=4 directed cases
        applyStimulus(1, "w16_full", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 32'hFFFE0001);
        applyStimulus(1, "w16_trunc", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'h00000001);
        applyStimulus(1, "w16_s_min", 16'h8000, 16'h8000, 1'b1, 1'b1, 32'h40000000);

        // Random operands on both instances
        for (int i = 0; i < 32; i++) begin
            sel = i % 2;
            w   = (sel == 0) ? 8 : 16;
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rf  = 1'($urandom);
            rs  = 1'($urandom);
            applyStimulus(sel, "rand", ra, rb, rf, rs, ref_model(w, ra, rb, rf, rs));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
